ram_dump_arbiter: RTL

//  Shares the single data-RAM port between the CPU and an end-of-run dump engine.

---
 rtl/ram_dump_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/ram_dump_arbiter.sv
// Shares the data-RAM port between the CPU and an end-of-run dump engine that
// streams RAM[DUMP_FIRST..DUMP_LAST] out on a valid/ready interface.
module ram_dump_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 63,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_done,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              dump_active,
    output logic              dump_done,
    output logic              cpu_conflict
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(DUMP_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DUMP_LAST);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  wcnt;
    logic              cpu_done_q;
    logic              start;
    logic              hs;

    assign start       = cpu_done & ~cpu_done_q;
    assign hs          = tx_valid & tx_ready;
    assign dump_active = (state != IDLE);
    assign dump_done   = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ram_addr = ptr;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = cpu_addr;
                ram_we   = cpu_we;
                ram_re   = cpu_re;
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                ram_re   = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    if (wcnt == '0) state_nx = SEND;
            SEND:    if (hs) state_nx = (ptr == LAST_A) ? DONE : ISSUE;
            DONE:    if (!cpu_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= FIRST_A;
            wcnt         <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            cpu_done_q   <= 1'b0;
            cpu_conflict <= 1'b0;
        end else begin
            cpu_done_q <= cpu_done;
            // CPU writes issued while the dump owns the port are lost; remember that.
            if (state != IDLE && cpu_we) cpu_conflict <= 1'b1;
            case (state)
                IDLE:  if (start) ptr <= FIRST_A;
                ISSUE: wcnt <= CNT_INIT;
                WAIT: begin
                    if (wcnt == '0) begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        // Stop at the last address without incrementing, so ptr never wraps.
                        if (ptr != LAST_A) ptr <= ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
